// File: rtl/data_mem_responder_if.sv
// Data-memory request/response handshake between the core's MEM stage (master)
// and a memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [2:0]  resp_exc;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_exc
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_exc
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding word-addressed data memory with programmable wait states,
// byte strobes and a 3-bit memory exception code.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [2:0] EXC_NONE = 3'b000;
  localparam logic [2:0] EXC_MIS  = 3'b001;
  localparam logic [2:0] EXC_OOR  = 3'b010;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
  } req_t;

  state_t      state;
  logic [3:0]  cnt;
  req_t        req_q, req_in, acc;
  logic [2:0]  exc_in;
  logic        mem_en;
  logic        resp_valid;
  logic [31:0] rdata;
  logic [2:0]  exc;
  logic [31:0] mem [DEPTH];

  always_comb begin
    req_in = '{we: bus.req_we, idx: bus.req_addr[DEPTH_LOG2+1:2],
               wdata: bus.req_wdata, wstrb: bus.req_wstrb};
    exc_in = EXC_NONE;
    if (bus.req_addr[1:0] != 2'b00)
      exc_in = EXC_MIS;
    else if ((bus.req_addr >> (DEPTH_LOG2 + 2)) != 32'd0)
      exc_in = EXC_OOR;
  end

  // With no wait states the access uses the live request on the accepting edge.
  assign acc    = (state == IDLE) ? req_in : req_q;
  assign mem_en = rst_n && ((state == WAIT && cnt == 4'd0) ||
                  (WAIT_CYCLES == 0 && state == IDLE && bus.req_valid && exc_in == EXC_NONE));

  // Array has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_en && acc.we)
      for (int i = 0; i < 4; i++)
        if (acc.wstrb[i]) mem[acc.idx][8*i +: 8] <= acc.wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      rdata      <= 32'd0;
      exc        <= EXC_NONE;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          req_q <= req_in;
          exc   <= exc_in;
          rdata <= (mem_en && !req_in.we) ? mem[req_in.idx] : 32'd0;
          if (exc_in != EXC_NONE || WAIT_CYCLES == 0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: if (cnt == 4'd0) begin
          state      <= RESP;
          resp_valid <= 1'b1;
          if (!req_q.we) rdata <= mem[req_q.idx];
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (bus.resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = rdata;
  assign bus.resp_exc   = exc;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: dut u[0] has 2 wait states, u[1] has none; the driver pushes
// expected responses, per-dut monitors pop and compare.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid, resp_ready, rv, rdy;
  logic req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0] req_wstrb;
  logic [1:0][31:0] rdata;
  logic [1:0][2:0] exc;
  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic [2:0]  exc;
    int          lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wc(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    data_mem_responder_if bus();
    assign bus.req_valid  = req_valid[g];
    assign bus.req_we     = req_we;
    assign bus.req_addr   = req_addr;
    assign bus.req_wdata  = req_wdata;
    assign bus.req_wstrb  = req_wstrb;
    assign bus.resp_ready = resp_ready[g];
    assign rv[g]    = bus.resp_valid;
    assign rdy[g]   = bus.req_ready;
    assign rdata[g] = bus.resp_rdata;
    assign exc[g]   = bus.resp_exc;

    data_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(g == 0 ? 2 : 0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));

    bit seen = 1'b0;
    logic [31:0] hold_d;
    logic [2:0] hold_e;
    exp_t e;
    always @(negedge clk) begin
      if (!rst_n) seen = 1'b0;
      else if (rv[g] === 1'b1) begin
        if (!seen) begin
          if (exp_q.size() == 0) check("unexpected_resp", 32'(rv[g]), 32'd0);
          else if (exp_q[0].dut != g) check("unexpected_resp", 32'(rv[g]), 32'd0);
          else begin
            e = exp_q.pop_front();
            check("resp_rdata", rdata[g], e.rdata);
            check("resp_exc", 32'(exc[g]), 32'(e.exc));
            check("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
          end
          seen = 1'b1;
          hold_d = rdata[g];
          hold_e = exc[g];
        end else begin
          check("stall_rdata_stable", rdata[g], hold_d);
          check("stall_exc_stable", 32'(exc[g]), 32'(hold_e));
        end
        check("req_ready_busy", 32'(rdy[g]), 32'd0);
        if (resp_ready[g]) seen = 1'b0;
      end
    end
  end

  task automatic issue(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] erd, input logic [2:0] eexc,
                       output int acc);
    int n = 0;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = wd; req_wstrb = st; req_valid[d] = 1'b1;
    while (!(rdy[d] && rst_n) && n < 50) begin @(negedge clk); n++; end
    acc = cyc;
    if (n >= 50) begin
      check("accept_timeout", 32'(rdy[d]), 32'd1);
    end else begin
      exp_q.push_back('{d, erd, eexc, (eexc != 3'b000 || wc(d) == 0) ? 1 : wc(d) + 1, cyc});
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while ((exp_q.size() != 0 || !rdy[d]) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("resp_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic txn(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input logic [31:0] erd, input logic [2:0] eexc);
    int acc;
    issue(d, we, a, wd, st, erd, eexc, acc);
    wait_done(d);
  endtask

  initial begin
    int acc, c0, n;
    req_valid = 2'b11; resp_ready = 2'b11;
    req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
    // reset held with requests pending
    repeat (3) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        check("rst_resp_valid", 32'(rv[g]), 32'd0);
        check("rst_resp_exc", 32'(exc[g]), 32'd0);
        check("rst_resp_rdata", rdata[g], 32'd0);
        check("rst_req_ready", 32'(rdy[g]), 32'd1);
      end
    end
    rst_n = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    for (int g = 0; g < 2; g++) check("post_rst_ready", 32'(rdy[g]), 32'd1);

    txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 3'b000);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 3'b000);
    txn(0, 1, 32'h20, 32'h0, 4'hF, 32'h0, 3'b000);
    txn(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 3'b000);
    txn(0, 0, 32'h20, 32'h0, 4'hF, 32'h00BB00DD, 3'b000);
    txn(0, 0, 32'h13, 32'h0, 4'h0, 32'h0, 3'b001);
    txn(0, 0, 32'h1000, 32'h0, 4'h0, 32'h0, 3'b010);
    txn(0, 0, 32'h1001, 32'h0, 4'h0, 32'h0, 3'b001);
    txn(0, 1, 32'h0, 32'h12345678, 4'hF, 32'h0, 3'b000);
    txn(0, 1, 32'h1002, 32'hFFFFFFFF, 4'hF, 32'h0, 3'b001);
    txn(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 3'b010);
    txn(0, 0, 32'h0, 32'h0, 4'h0, 32'h12345678, 3'b000);

    // backpressure: response stalls while a new request waits
    resp_ready[0] = 1'b0;
    issue(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 3'b000, acc);
    n = 0;
    while (rv[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("stall_resp_seen", 32'(rv[0]), 32'd1);
    req_we = 1'b0; req_addr = 32'h20; req_valid[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("stall_valid_held", 32'(rv[0]), 32'd1);
    resp_ready[0] = 1'b1;
    c0 = cyc;
    issue(0, 0, 32'h20, 32'h0, 4'h0, 32'h00BB00DD, 3'b000, acc);
    check("accept_after_hs", 32'(acc), 32'(c0 + 1));
    wait_done(0);

    // reset while a store waits: store is dropped, no response
    txn(0, 1, 32'h30, 32'h11111111, 4'hF, 32'h0, 3'b000);
    issue(0, 1, 32'h30, 32'h22222222, 4'hF, 32'h0, 3'b000, acc);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("rst_mid_ready", 32'(rdy[0]), 32'd1);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_resp_after_rst", 32'(rv[0]), 32'd0);
    end
    txn(0, 0, 32'h30, 32'h0, 4'h0, 32'h11111111, 3'b000);

    // zero wait states
    txn(1, 1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, 3'b000);
    txn(1, 0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, 3'b000);
    txn(1, 1, 32'h40, 32'h00005500, 4'b0010, 32'h0, 3'b000);
    txn(1, 0, 32'h40, 32'h0, 4'h0, 32'hCAFE550D, 3'b000);
    txn(1, 0, 32'h13, 32'h0, 4'h0, 32'h0, 3'b001);
    txn(1, 0, 32'h2000, 32'h0, 4'h0, 32'h0, 3'b010);

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
